// File: rtl/axon_spike_scheduler_if.sv
// Bundle of signals between an axon_spike_scheduler and its neighbours.
//
// Handshake (enable / synap_con_done): the scheduler raises enable together
// with a valid axon_number and holds both stable until it samples
// synap_con_done=1 on a rising clock edge. At that edge enable drops. enable
// stays low for at least one cycle before the next axon is presented.
// synap_con_done while enable is low has no effect.
//
// Signals:
//   spike_in_valid / spike_in_axon : spike write into the collecting buffer
//   tick                           : starts processing of the collected spikes
//   synap_con_done                 : downstream finished the presented axon
//   axon_number / enable           : axon request to synapse_connection
//   busy / tick_done / tick_error  : tick status
//   issued_count                   : axons issued in the last or current tick
//   dbg_state                      : scheduler FSM state, for observation
// Modports: master = upstream/downstream environment, slave = scheduler.
interface axon_spike_scheduler_if #(
    parameter int NUM_AXONS = 256
);
    localparam int AXON_W = $clog2(NUM_AXONS);

    logic              spike_in_valid;
    logic [AXON_W-1:0] spike_in_axon;
    logic              tick;
    logic              synap_con_done;
    logic [AXON_W-1:0] axon_number;
    logic              enable;
    logic              busy;
    logic              tick_done;
    logic              tick_error;
    logic [AXON_W:0]   issued_count;
    logic [1:0]        dbg_state;

    modport master (
        output spike_in_valid, spike_in_axon, tick, synap_con_done,
        input  axon_number, enable, busy, tick_done, tick_error, issued_count, dbg_state
    );

    modport slave (
        input  spike_in_valid, spike_in_axon, tick, synap_con_done,
        output axon_number, enable, busy, tick_done, tick_error, issued_count, dbg_state
    );
endinterface

// File: rtl/axon_spike_scheduler.sv
// axon_spike_scheduler
// Collects axon spikes for the next tick in a double-buffered bit vector.
// On an accepted tick the buffers swap and the read buffer is scanned in
// ascending axon order; every set axon is handed to synapse_connection via
// one enable/synap_con_done handshake, then tick_done pulses.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : axon_spike_scheduler_if.slave (spike input, tick, handshake,
//          status outputs and FSM debug state)
module axon_spike_scheduler #(
    parameter int NUM_AXONS = 256
) (
    input logic                   clk,
    input logic                   rst,
    axon_spike_scheduler_if.slave bus
);
    localparam int AXON_W = $clog2(NUM_AXONS);
    localparam logic [AXON_W-1:0] LAST_AXON = AXON_W'(NUM_AXONS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                           state_q, state_d;
    logic [AXON_W-1:0]                ptr_q, ptr_d;
    logic                             sel_q, sel_d;    // index of the read buffer
    logic [1:0][NUM_AXONS-1:0]        buf_q, buf_d;
    logic [AXON_W-1:0]                axon_q, axon_d;
    logic                             enable_q, enable_d;
    logic                             err_q, err_d;
    logic [AXON_W:0]                  cnt_q, cnt_d;
    logic                             spike_in_range;

    // Only matters when NUM_AXONS is not a power of two.
    assign spike_in_range = ({1'b0, bus.spike_in_axon} < (AXON_W + 1)'(NUM_AXONS));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        buf_d    = buf_q;
        axon_d   = axon_q;
        enable_d = enable_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.tick) begin
                    // The old read buffer is all-zero after its scan and
                    // becomes the new write buffer.
                    sel_d   = ~sel_q;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (buf_q[sel_q][ptr_q]) begin
                    axon_d   = ptr_q;
                    enable_d = 1'b1;
                    cnt_d    = cnt_q + (AXON_W + 1)'(1);
                    state_d  = S_WAIT;
                end else if (ptr_q == LAST_AXON) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + AXON_W'(1);
                end
            end
            S_WAIT: begin
                if (bus.synap_con_done) begin
                    enable_d             = 1'b0;
                    buf_d[sel_q][ptr_q]  = 1'b0;
                    if (ptr_q == LAST_AXON) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + AXON_W'(1);
                        state_d = S_SEARCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.tick && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end

        // Written into the buffer that is the write buffer after this edge,
        // so a spike coinciding with an accepted tick belongs to the next tick.
        // The read-buffer clear above never targets this buffer.
        if (bus.spike_in_valid && spike_in_range) begin
            buf_d[~sel_d][bus.spike_in_axon] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            sel_q    <= 1'b0;
            buf_q    <= '0;
            axon_q   <= '0;
            enable_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            buf_q    <= buf_d;
            axon_q   <= axon_d;
            enable_q <= enable_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.axon_number  = axon_q;
    assign bus.enable       = enable_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.tick_done    = (state_q == S_DONE);
    assign bus.tick_error   = err_q;
    assign bus.issued_count = cnt_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_axon_spike_scheduler.sv
module tb_axon_spike_scheduler;
    localparam int N  = 256;
    localparam int AW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axon_spike_scheduler_if #(.NUM_AXONS(N)) bus();

    axon_spike_scheduler #(.NUM_AXONS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model / scoreboard state ----------------
    typedef struct {
        int t_edge;
        int count;
    } done_exp_t;

    bit             model_w [N];       // spikes collected for the next tick
    logic [AW-1:0]  exp_q[$];          // expected axon issue order
    done_exp_t      done_q[$];         // expected tick completions
    int             wait_sum   = 0;    // handshake cycles added in current tick
    int             exp_err    = 0;
    int             seen_err   = 0;
    int             done_seen  = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic spike(input int a);
        @(negedge clk);
        bus.spike_in_valid = 1'b1;
        bus.spike_in_axon  = AW'(a);
        model_w[a] = 1'b1;
        @(posedge clk);
        #1;
        bus.spike_in_valid = 1'b0;
    endtask

    // Tick while idle: the collected set is issued in ascending order.
    task automatic do_tick(input bit with_spike, input int sa);
        int cnt;
        @(negedge clk);
        bus.tick = 1'b1;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (model_w[i]) begin
                exp_q.push_back(AW'(i));
                cnt++;
                model_w[i] = 1'b0;
            end
        end
        done_q.push_back('{t_edge: cyc + 1, count: cnt});
        if (with_spike) begin
            bus.spike_in_valid = 1'b1;
            bus.spike_in_axon  = AW'(sa);
            model_w[sa] = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.tick           = 1'b0;
        bus.spike_in_valid = 1'b0;
    endtask

    task automatic busy_tick();
        @(negedge clk);
        bus.tick = 1'b1;
        exp_err++;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = done_seen;
        n = 0;
        while (done_seen == start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_tick_done", done_seen - start, 1);
    endtask

    // ---------------- downstream responder ----------------
    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = 0;
        bus.synap_con_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.enable && !bus.synap_con_done && !rst) begin
                if (cnt == 0) begin
                    lat = $urandom_range(1, 4);
                    wait_sum += lat;
                end
                cnt++;
                if (cnt == lat) bus.synap_con_done = 1'b1;
            end else begin
                bus.synap_con_done = 1'b0;
                cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic          prev_en;
        logic [AW-1:0] held;
        logic [AW-1:0] e;
        done_exp_t     d;
        prev_en = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 1'b0;
            end else begin
                if (bus.enable && !prev_en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_enable", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("axon_number", int'(bus.axon_number), int'(e));
                    end
                    held = bus.axon_number;
                end else if (bus.enable && prev_en) begin
                    check("axon_hold", int'(bus.axon_number), int'(held));
                end
                if (bus.tick_error) seen_err++;
                if (bus.tick_done) begin
                    done_seen++;
                    if (done_q.size() == 0) begin
                        check("unexpected_tick_done", 1, 0);
                    end else begin
                        d = done_q.pop_front();
                        check("issued_count", int'(bus.issued_count), d.count);
                        check("tick_done_cycle", cyc, d.t_edge + N + wait_sum);
                        check("pending_issues", exp_q.size(), 0);
                    end
                    wait_sum = 0;
                end
                prev_en = bus.enable;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst                = 1'b1;
        bus.spike_in_valid = 1'b0;
        bus.spike_in_axon  = '0;
        bus.tick           = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_enable", int'(bus.enable), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_tick_done", int'(bus.tick_done), 0);
        check("reset_tick_error", int'(bus.tick_error), 0);
        check("reset_issued_count", int'(bus.issued_count), 0);
        check("reset_axon_number", int'(bus.axon_number), 0);

        // Empty tick
        do_tick(1'b0, 0);
        wait_done();

        // Ordered issue with a duplicate spike
        spike(200); spike(3); spike(3); spike(77);
        do_tick(1'b0, 0);
        wait_done();

        // Boundary axons
        spike(0); spike(255);
        do_tick(1'b0, 0);
        wait_done();

        // Overlap: spike and tick while a scan runs
        spike(40); spike(41);
        do_tick(1'b0, 0);
        repeat (5) @(negedge clk);
        spike(10);
        busy_tick();
        wait_done();
        do_tick(1'b0, 0);
        wait_done();

        // Same-cycle spike and tick
        spike(20);
        do_tick(1'b1, 5);
        wait_done();
        do_tick(1'b0, 0);
        wait_done();

        // Randomized ticks with spikes arriving before and during scans
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 10);
            for (int k = 0; k < n; k++) spike($urandom_range(0, N - 1));
            if ($urandom_range(0, 1) == 1) spike(N - 1);
            do_tick($urandom_range(0, 1) == 1, $urandom_range(0, N - 1));
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) spike($urandom_range(0, N - 1));
            if ($urandom_range(0, 2) == 0) busy_tick();
            wait_done();
        end
        // Flush whatever the random phase left collected
        do_tick(1'b0, 0);
        wait_done();

        // Async reset during WAIT on axon 77
        spike(77); spike(200);
        do_tick(1'b0, 0);
        n = 0;
        while (!(bus.enable && bus.axon_number == AW'(77)) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_77", int'(bus.enable && bus.axon_number == AW'(77)), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_enable", int'(bus.enable), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_axon_number", int'(bus.axon_number), 0);
        exp_q.delete();
        done_q.delete();
        for (int i = 0; i < N; i++) model_w[i] = 1'b0;
        wait_sum = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_tick(1'b0, 0);
        wait_done();

        repeat (3) @(negedge clk);
        check("tick_error_pulses", seen_err, exp_err);
        check("leftover_issues", exp_q.size(), 0);
        check("leftover_ticks", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
